// File: rtl/systolic_psum_drain.sv
// Collects skewed column partial sums from the bottom of a systolic array, deskews them
// into aligned rows, requantizes each lane and buffers the rows in a FWFT FIFO.
module systolic_psum_drain #(
   parameter int COLS       = 4,
   parameter int ACC_W      = 24,
   parameter int OUT_W      = 8,
   parameter int SHIFT_W    = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   input  logic [COLS*ACC_W-1:0]            psum_in,
   input  logic [SHIFT_W-1:0]               shift_amt,
   input  logic                             round_en,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [COLS*OUT_W-1:0]            out_data,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
   output logic                             overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DLY   = COLS - 1;

   logic [DLY-1:0]                  r_validPipe;
   logic                            w_alignValid;
   logic [COLS-1:0][ACC_W-1:0]      w_aligned;
   logic [COLS*OUT_W-1:0]           w_qData;
   logic                            r_qValid;
   logic [COLS*OUT_W-1:0]           r_qData;
   logic [COLS*OUT_W-1:0]           r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]                r_wrPtr;
   logic [PTR_W-1:0]                r_rdPtr;
   logic [CNT_W-1:0]                r_count;
   logic                            r_overflow;
   logic [COLS*OUT_W-1:0]           r_lastData;
   logic                            w_pop;
   logic                            w_full;
   logic                            w_accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_validPipe <= '0;
      end else begin
         r_validPipe[0] <= in_valid;
         for (int i = 1; i < DLY; i++) r_validPipe[i] <= r_validPipe[i-1];
      end
   end

   assign w_alignValid = r_validPipe[DLY-1];

   // Lane c trails lane 0 by c cycles, so it gets COLS-1-c stages to line up with the last lane.
   for (genvar c = 0; c < COLS; c++) begin : g_lane
      localparam int D = COLS - 1 - c;
      if (D == 0) begin : g_direct
         assign w_aligned[c] = psum_in[c*ACC_W +: ACC_W];
      end else begin : g_dly
         logic [ACC_W-1:0] r_dly [D];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < D; i++) r_dly[i] <= '0;
            end else begin
               r_dly[0] <= psum_in[c*ACC_W +: ACC_W];
               for (int i = 1; i < D; i++) r_dly[i] <= r_dly[i-1];
            end
         end
         assign w_aligned[c] = r_dly[D-1];
      end
   end

   // Two guard bits keep the rounding add from wrapping even for the largest shifts.
   function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] p,
                                                input logic [SHIFT_W-1:0] sh,
                                                input logic rnd);
      logic [ACC_W+1:0] x;
      logic [ACC_W+1:0] y;
      logic [OUT_W-1:0] res;
      x = {2'b00, p};
      if (rnd && (sh != '0)) x = x + ((ACC_W+2)'(1) << (sh - 1'b1));
      y = x >> sh;
      if (32'(sh) >= ACC_W + 1) res = '0;
      else if (|y[ACC_W+1:OUT_W]) res = '1;
      else res = y[OUT_W-1:0];
      return res;
   endfunction

   always_comb begin
      w_qData = '0;
      for (int c = 0; c < COLS; c++) begin
         w_qData[c*OUT_W +: OUT_W] = requant(w_aligned[c], shift_amt, round_en);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_qValid <= 1'b0;
         r_qData  <= '0;
      end else begin
         r_qValid <= w_alignValid;
         r_qData  <= w_qData;
      end
   end

   assign w_pop    = out_valid && out_ready;
   assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_accept = r_qValid && (!w_full || w_pop);

   // Storage needs no reset: it is only visible through the head while count is nonzero.
   always_ff @(posedge clk) begin
      if (w_accept) r_mem[r_wrPtr] <= r_qData;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_lastData <= '0;
      end else begin
         if (w_accept) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop) begin
            r_rdPtr    <= r_rdPtr + 1'b1;
            r_lastData <= r_mem[r_rdPtr];
         end
         if (r_qValid && !w_accept) r_overflow <= 1'b1;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // When empty the last popped row stays on the bus instead of stale storage.
   assign out_valid  = (r_count != '0);
   assign out_data   = out_valid ? r_mem[r_rdPtr] : r_lastData;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_systolic_psum_drain.sv
// Directed bench for systolic_psum_drain: quantization vector table plus hand-written
// sequences for alignment, streaming, overflow, full push/pop and mid-stream reset.
module tb_systolic_psum_drain;

   localparam int COLS       = 4;
   localparam int ACC_W      = 24;
   localparam int OUT_W      = 8;
   localparam int SHIFT_W    = 5;
   localparam int FIFO_DEPTH = 8;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        in_valid;
   logic [COLS*ACC_W-1:0]       psum_in;
   logic [SHIFT_W-1:0]          shift_amt;
   logic                        round_en;
   logic                        out_valid;
   logic                        out_ready;
   logic [COLS*OUT_W-1:0]       out_data;
   logic [CNT_W-1:0]            fifo_count;
   logic                        overflow;

   typedef struct {
      logic [ACC_W-1:0]   psum;
      logic [SHIFT_W-1:0] sh;
      logic               rnd;
      logic [OUT_W-1:0]   expected;
   } quantVec_t;

   quantVec_t              vecs[16];
   logic [COLS*ACC_W-1:0]  rowIn[32];
   logic [COLS*OUT_W-1:0]  rowExp[32];
   logic [COLS*OUT_W-1:0]  gotRows[$];
   int                     nChecks = 0;
   int                     nPass   = 0;

   systolic_psum_drain #(
      .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .psum_in(psum_in),
      .shift_amt(shift_amt), .round_en(round_en), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .fifo_count(fifo_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
   endtask

   task automatic reportTimeout(input string name);
      nChecks++;
      $display("[TB] FAIL %s: out_valid never rose within the cycle budget", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setRow(input int idx, input logic [7:0] base);
      for (int c = 0; c < COLS; c++) begin
         rowIn[idx][c*ACC_W +: ACC_W] = ACC_W'(base) + ACC_W'(c);
         rowExp[idx][c*OUT_W +: OUT_W] = base + 8'(c);
      end
   endtask

   // Lane c of row r is presented c cycles after that row's in_valid.
   task automatic sendRows(input int first, input int n);
      for (int k = 0; k < n + COLS - 1; k++) begin
         in_valid = (k < n);
         for (int c = 0; c < COLS; c++) begin
            int r;
            r = k - c;
            if (r >= 0 && r < n) psum_in[c*ACC_W +: ACC_W] = rowIn[first+r][c*ACC_W +: ACC_W];
            else psum_in[c*ACC_W +: ACC_W] = 24'hBAD000 + 24'(c);
         end
         step();
      end
      in_valid = 1'b0;
      psum_in  = '0;
   endtask

   task automatic drainRows(input int maxCycles);
      gotRows.delete();
      out_ready = 1'b1;
      for (int i = 0; i < maxCycles; i++) begin
         @(negedge clk);
         if (out_valid) gotRows.push_back(out_data);
         step();
      end
      out_ready = 1'b0;
   endtask

   task automatic applyStimulus(input int idx);
      bit seen;
      shift_amt = vecs[idx].sh;
      round_en  = vecs[idx].rnd;
      rowIn[20] = {COLS{vecs[idx].psum}};
      sendRows(20, 1);
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         if (out_valid) seen = 1'b1;
         else step();
      end
      if (seen) checkOutput($sformatf("quant[%0d]", idx), 64'(out_data), 64'({COLS{vecs[idx].expected}}));
      else reportTimeout($sformatf("quant[%0d]_wait", idx));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int firstCyc;
      int lastCyc;
      int cyc;
      int maxCnt;
      bit popSeen;
      bit sawValid;

      vecs[0]  = '{24'h000108, 5'd4,  1'b0, 8'h10};
      vecs[1]  = '{24'h000108, 5'd4,  1'b1, 8'h11};
      vecs[2]  = '{24'h010000, 5'd4,  1'b0, 8'hFF};
      vecs[3]  = '{24'h000000, 5'd4,  1'b1, 8'h00};
      vecs[4]  = '{24'h0000FF, 5'd0,  1'b1, 8'hFF};
      vecs[5]  = '{24'h000100, 5'd0,  1'b0, 8'hFF};
      vecs[6]  = '{24'hFFFFFF, 5'd25, 1'b1, 8'h00};
      vecs[7]  = '{24'hFFFFFF, 5'd24, 1'b0, 8'h00};
      vecs[8]  = '{24'hFFFFFF, 5'd24, 1'b1, 8'h01};
      vecs[9]  = '{24'h000017, 5'd1,  1'b1, 8'h0C};
      vecs[10] = '{24'h000017, 5'd1,  1'b0, 8'h0B};
      vecs[11] = '{24'hFFFFFF, 5'd16, 1'b0, 8'hFF};
      vecs[12] = '{24'hFFFFFF, 5'd16, 1'b1, 8'hFF};
      vecs[13] = '{24'h00FE7F, 5'd8,  1'b1, 8'hFE};
      vecs[14] = '{24'h00FE80, 5'd8,  1'b1, 8'hFF};
      vecs[15] = '{24'hFFFFFF, 5'd31, 1'b1, 8'h00};

      rst = 1'b1; in_valid = 1'b0; psum_in = '0; shift_amt = '0; round_en = 1'b0; out_ready = 1'b0;
      repeat (3) step();
      checkOutput("reset_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_data", 64'(out_data), 64'd0);
      checkOutput("reset_count", 64'(fifo_count), 64'd0);
      checkOutput("reset_overflow", 64'(overflow), 64'd0);
      rst = 1'b0;
      step();

      // Alignment: row tagged at t must show up in cycle t+5, not t+4.
      setRow(0, 8'h10);
      sendRows(0, 1);
      checkOutput("align_early_valid", 64'(out_valid), 64'd0);
      step();
      checkOutput("align_valid", 64'(out_valid), 64'd1);
      checkOutput("align_data", 64'(out_data), 64'h13121110);
      checkOutput("align_count", 64'(fifo_count), 64'd1);
      step();
      checkOutput("align_hold_data", 64'(out_data), 64'h13121110);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("align_pop_count", 64'(fifo_count), 64'd0);
      checkOutput("align_pop_valid", 64'(out_valid), 64'd0);
      checkOutput("align_empty_data_held", 64'(out_data), 64'h13121110);

      for (int i = 0; i < 16; i++) applyStimulus(i);

      // Streaming with out_ready held high.
      shift_amt = '0; round_en = 1'b0;
      for (int r = 1; r <= 4; r++) setRow(r, 8'(8'h20 + 4*(r-1)));
      gotRows.delete();
      out_ready = 1'b1;
      firstCyc = -1; lastCyc = -1; maxCnt = 0; popSeen = 1'b0;
      fork
         sendRows(1, 4);
         begin
            for (cyc = 0; cyc < 16; cyc++) begin
               @(negedge clk);
               if (popSeen && int'(fifo_count) > maxCnt) maxCnt = int'(fifo_count);
               if (out_valid && out_ready) begin
                  if (firstCyc < 0) firstCyc = cyc;
                  lastCyc = cyc;
                  popSeen = 1'b1;
                  gotRows.push_back(out_data);
               end
            end
         end
      join
      out_ready = 1'b0;
      step();
      checkOutput("stream_rows", 64'(gotRows.size()), 64'd4);
      for (int r = 0; r < 4 && r < gotRows.size(); r++)
         checkOutput($sformatf("stream_row%0d", r), 64'(gotRows[r]), 64'(rowExp[1+r]));
      checkOutput("stream_consecutive", 64'(lastCyc - firstCyc), 64'd3);
      checkOutput("stream_count_le1", 64'(maxCnt <= 1), 64'd1);
      checkOutput("stream_overflow", 64'(overflow), 64'd0);

      // Overflow: nine rows into an eight-row FIFO with no drain.
      for (int r = 5; r <= 13; r++) setRow(r, 8'(8'h40 + 4*(r-5)));
      sendRows(5, 9);
      step(); step();
      checkOutput("ovf_count", 64'(fifo_count), 64'd8);
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      checkOutput("ovf_head", 64'(out_data), 64'(rowExp[5]));
      drainRows(12);
      checkOutput("ovf_drain_rows", 64'(gotRows.size()), 64'd8);
      for (int r = 0; r < 8 && r < gotRows.size(); r++)
         checkOutput($sformatf("ovf_row%0d", r), 64'(gotRows[r]), 64'(rowExp[5+r]));
      checkOutput("ovf_sticky", 64'(overflow), 64'd1);
      checkOutput("ovf_drained_count", 64'(fifo_count), 64'd0);

      // Reset while three rows are buffered and more are still in the pipeline.
      for (int r = 14; r <= 18; r++) setRow(r, 8'(8'h80 + 4*(r-14)));
      fork
         sendRows(14, 5);
         begin
            repeat (7) @(posedge clk);
            #1;
            checkOutput("rstmid_pre_count", 64'(fifo_count), 64'd3);
            rst = 1'b1;
            step();
            rst = 1'b0;
            checkOutput("rstmid_valid", 64'(out_valid), 64'd0);
            checkOutput("rstmid_count", 64'(fifo_count), 64'd0);
            checkOutput("rstmid_overflow", 64'(overflow), 64'd0);
         end
      join
      sawValid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      step();
      checkOutput("rstmid_no_stale_row", 64'(sawValid), 64'd0);
      checkOutput("rstmid_final_count", 64'(fifo_count), 64'd0);

      // Full FIFO with a push and a pop on the same edge.
      for (int r = 19; r <= 26; r++) setRow(r, 8'(8'hA0 + 4*(r-19)));
      setRow(27, 8'hC8);
      sendRows(19, 8);
      step(); step();
      checkOutput("fullpp_pre_count", 64'(fifo_count), 64'd8);
      sendRows(27, 1);
      out_ready = 1'b1;
      checkOutput("fullpp_head", 64'(out_data), 64'(rowExp[19]));
      step();
      out_ready = 1'b0;
      checkOutput("fullpp_count", 64'(fifo_count), 64'd8);
      checkOutput("fullpp_overflow", 64'(overflow), 64'd0);
      drainRows(12);
      checkOutput("fullpp_drain_rows", 64'(gotRows.size()), 64'd8);
      for (int r = 0; r < 8 && r < gotRows.size(); r++)
         checkOutput($sformatf("fullpp_row%0d", r), 64'(gotRows[r]), 64'(rowExp[20+r]));

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/systolic_psum_drain.md
Name: systolic_psum_drain

Overview:
Output-side collector for a row of pe_systolic columns. It captures the skewed partial sums leaving the bottom of COLS columns and deskews them into one aligned row. Each lane is then requantized (round, shift, saturate) to OUT_W bits and buffered in a FIFO. A valid/ready stream drains the FIFO to the next layer or writeback. The array cannot stall, so the FIFO absorbs back-pressure and overflow is flagged rather than propagated.

Parameters:
COLS, 4, number of array columns / output lanes
ACC_W, 24, partial-sum width from the array (unsigned)
OUT_W, 8, requantized lane width (unsigned)
SHIFT_W, 5, width of right-shift control
FIFO_DEPTH, 8, rows of output buffering (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  column 0 psum valid this cycle; column c of the same row arrives c cycles later
psum_in  in  COLS*ACC_W  bottom psum_out of each column, lane c = bits [c*ACC_W +: ACC_W]
shift_amt  in  SHIFT_W  requant right shift; static config, changed only when idle
round_en  in  1  add 2^(shift_amt-1) before shifting when shift_amt>0; static config
out_valid  out  1  FIFO head row available
out_ready  in  1  downstream accepts head row
out_data  out  COLS*OUT_W  head row, lane c = bits [c*OUT_W +: OUT_W]
fifo_count  out  clog2(FIFO_DEPTH)+1  rows currently buffered
overflow  out  1  sticky: a row was dropped because FIFO was full

Behaviour:
- Reset: all deskew registers, valid pipeline, FIFO pointers and quant stage clear. out_valid=0, out_data=0, fifo_count=0, overflow=0. Reset mid-operation discards every in-flight and buffered row.
- Deskew: lane c is delayed by (COLS-1-c) registers, so lane COLS-1 has no delay. in_valid is delayed by COLS-1 registers. At cycle t+COLS-1 all lanes of the row tagged at cycle t are aligned.
- Back-to-back in_valid every cycle is supported. Rows never merge because each lane has its own shift register.
- Quant stage (registered, one cycle), per lane:
  - x = psum (ACC_W+1 bits, zero-extended).
  - If round_en and shift_amt>0, x += 1<<(shift_amt-1).
  - y = x >> shift_amt.
  - If y > 2^OUT_W-1, lane = 2^OUT_W-1 (saturate); else lane = y[OUT_W-1:0].
  - shift_amt >= ACC_W+1 yields 0.
- Latency: the row tagged at cycle t is pushed on the clock edge ending cycle t+COLS. out_valid rises in cycle t+COLS+1 if the FIFO was empty.
- FIFO: first-word-fall-through. out_data shows the head whenever out_valid=1; out_data is held (not cleared) when empty. A pop occurs on any edge with out_valid && out_ready.
- out_data and out_valid hold stable while out_valid && !out_ready.
- Full, push without pop: the row is dropped, overflow is set to 1 and stays set until rst, count stays FIFO_DEPTH.
- Full, push and pop in the same cycle: both take effect, the row is not dropped, count is unchanged.
- Empty, pop: ignored, since out_valid=0.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_count updates on the same edge as each push/pop: +1, -1, or unchanged for simultaneous push and pop or no activity.

Test Plan:
- Alignment: COLS=4, shift=0, in_valid at t; lane c presents 0x10+c at cycle t+c -> out_valid at t+5, out_data lanes {0x13,0x12,0x11,0x10} (lane3..lane0).
- Round/shift/saturate: shift=4. psum 0x000108 with round_en=0 -> 0x10; with round_en=1 -> 0x11. psum 0x010000 -> 0xFF. psum 0 -> 0x00.
- Streaming: 4 rows back-to-back with out_ready=1 -> 4 consecutive out_valid cycles, data in order, fifo_count never exceeds 1 after the first pop, overflow=0.
- Overflow: out_ready=0, 9 rows -> fifo_count=8, overflow=1. Then raise out_ready -> exactly rows 1..8 emerge, row 9 is absent, overflow stays 1.
- Full with simultaneous push and pop: FIFO at 8 rows, out_ready=1 and a new row pushed on the same edge -> count stays 8, overflow=0, new row emerges last.
- Reset mid-stream: 3 rows buffered plus 1 in deskew, rst for 1 cycle -> out_valid=0, fifo_count=0, overflow=0, and no stale row appears afterwards.
